// File: rtl/ftdi_fifo_writer.sv
// ftdi_fifo_writer: FT600/FT601 245 sync FIFO write master, one packet per TXE_N grant.
// Define FTDI_TEST_PATTERN_EN to send a free-running counter instead of FIFO data.
module ftdi_fifo_writer #(
  parameter int PACKET_WORDS = 1024,
  parameter int USEDW_W      = 11,
  parameter int GAP_CYCLES   = 4
) (
  input  logic               iCLK,
  input  logic               iRST_N,
  input  logic [31:0]        iFIFO_DATA,
  input  logic [USEDW_W-1:0] iFIFO_USEDW,
  output logic               oFIFO_RD,
  input  logic               iTXE_N,
  inout  wire  [31:0]        ioDATA,
  inout  wire  [3:0]         ioBE,
  output logic               oWR_N,
  output logic               oOE_N,
  output logic               oRD_N,
  output logic [1:0]         oGPIO,
  output logic               oBUSY,
  output logic               oPKT_DONE
);

  localparam int CW = $clog2(PACKET_WORDS);
  localparam logic [CW-1:0] LAST   = CW'(PACKET_WORDS - 1);
  localparam logic [CW-1:0] PENULT = CW'(PACKET_WORDS - 2);
  localparam logic [CW-1:0] GLAST  = CW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    GAP
  } state_t;

  state_t      state;
  logic        txeQ;
  logic        wrN;
  logic        drvEn;
  logic        busy;
  logic        pktDone;
  logic [CW-1:0] wordCnt;
  logic [CW-1:0] gapCnt;
  logic [31:0] dataQ;
  logic [31:0] nextWord;
  logic        start;
  logic        more;
  logic        load;

  assign more = (state == WRITE) && (wordCnt != LAST);
  assign load = start | more;

`ifdef FTDI_TEST_PATTERN_EN
  logic [31:0] pattern;
  wire unusedPins = ^{iFIFO_DATA, iFIFO_USEDW};

  assign start    = (state == IDLE) && !txeQ;
  assign nextWord = pattern;
  assign oFIFO_RD = 1'b0;

  // Advances once per word handed to the bus, across packets.
  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      pattern <= '0;
    end else if (load) begin
      pattern <= pattern + 32'd1;
    end
  end
`else
  localparam logic [USEDW_W-1:0] PKT_LVL = USEDW_W'(PACKET_WORDS);

  assign start    = (state == IDLE) && !txeQ &&
                    (iFIFO_USEDW >= PKT_LVL);
  assign nextWord = iFIFO_DATA;
  assign oFIFO_RD = load;
`endif

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      state   <= IDLE;
      txeQ    <= 1'b1;
      wrN     <= 1'b1;
      drvEn   <= 1'b0;
      busy    <= 1'b0;
      pktDone <= 1'b0;
      wordCnt <= '0;
      gapCnt  <= '0;
      dataQ   <= '0;
    end else begin
      txeQ    <= iTXE_N;
      pktDone <= 1'b0;
      if (load) begin
        dataQ <= nextWord;
      end
      unique case (state)
        IDLE: begin
          if (start) begin
            state   <= WRITE;
            wrN     <= 1'b0;
            drvEn   <= 1'b1;
            busy    <= 1'b1;
            wordCnt <= '0;
          end
        end
        WRITE: begin
          // TXE_N is not consulted here: the full packet was granted at start.
          if (wordCnt == LAST) begin
            state  <= GAP;
            wrN    <= 1'b1;
            drvEn  <= 1'b0;
            gapCnt <= '0;
          end else begin
            wordCnt <= wordCnt + 1'b1;
            pktDone <= (wordCnt == PENULT);
          end
        end
        GAP: begin
          if (gapCnt == GLAST) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            gapCnt <= gapCnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          wrN   <= 1'b1;
          drvEn <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  assign ioDATA    = drvEn ? dataQ : 32'hzzzz_zzzz;
  assign ioBE      = drvEn ? 4'hF : 4'hz;
  assign oWR_N     = wrN;
  assign oOE_N     = 1'b1;
  assign oRD_N     = 1'b1;
  assign oGPIO     = 2'b00;
  assign oBUSY     = busy;
  assign oPKT_DONE = pktDone;

endmodule

// File: tb/tb_ftdi_fifo_writer.sv
// tb_ftdi_fifo_writer: scoreboard bench, FIFO/packet reference model vs DUT bus.
// Build with +define+FTDI_TEST_PATTERN_EN to exercise the pattern variant.
`timescale 1ns/1ps
module tb_ftdi_fifo_writer;

  localparam int PW  = 1024;
  localparam int UW  = 11;
  localparam int GAP = 4;

  logic          clk = 1'b0;
  logic          iRST_N;
  logic          iTXE_N;
  logic [31:0]   iFIFO_DATA;
  logic [UW-1:0] iFIFO_USEDW;
  logic          oFIFO_RD;
  wire  [31:0]   ioDATA;
  wire  [3:0]    ioBE;
  logic          oWR_N;
  logic          oOE_N;
  logic          oRD_N;
  logic [1:0]    oGPIO;
  logic          oBUSY;
  logic          oPKT_DONE;

  ftdi_fifo_writer #(
    .PACKET_WORDS(PW),
    .USEDW_W(UW),
    .GAP_CYCLES(GAP)
  ) dut (
    .iCLK(clk),
    .iRST_N(iRST_N),
    .iFIFO_DATA(iFIFO_DATA),
    .iFIFO_USEDW(iFIFO_USEDW),
    .oFIFO_RD(oFIFO_RD),
    .iTXE_N(iTXE_N),
    .ioDATA(ioDATA),
    .ioBE(ioBE),
    .oWR_N(oWR_N),
    .oOE_N(oOE_N),
    .oRD_N(oRD_N),
    .oGPIO(oGPIO),
    .oBUSY(oBUSY),
    .oPKT_DONE(oPKT_DONE)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [31:0] fifo[$];
  logic [31:0] expQ[$];
  int   acks     = 0;
  int   pkts     = 0;
  int   run      = 0;
  int   highRun  = 1000;
  int   cyc      = 0;
  int   startCyc = 0;
  bit   trunc    = 1'b0;
  bit   ackSeen  = 1'b0;
  logic h1 = 1'b1;
  logic h2 = 1'b1;
  logic [UW-1:0] uh1 = '0;
  logic [31:0]   patExp = '0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void drive();
    iFIFO_DATA  = (fifo.size() > 0) ? fifo[0] : 32'd0;
    iFIFO_USEDW = (fifo.size() > 2047) ? '1 : UW'(fifo.size());
  endfunction

  // One clock: acks seen in the finished cycle pop the model FIFO into the scoreboard.
  task automatic tick();
    @(posedge clk);
    #1;
    if (ackSeen) begin
      acks++;
      chk("fifo_underflow", fifo.size() > 0, 1);
      if (fifo.size() > 0) expQ.push_back(fifo.pop_front());
    end
    ackSeen = 1'b0;
    drive();
  endtask

  task automatic waitPkts(int n, int budget, string name);
    int k = 0;
    while (pkts < n && k < budget) begin
      tick();
      k++;
    end
    chk(name, pkts >= n, 1);
  endtask

  task automatic waitRun(int n, int budget, string name);
    int k = 0;
    while (run < n && k < budget) begin
      tick();
      k++;
    end
    chk(name, run >= n, 1);
  endtask

  always @(negedge clk) begin
    logic [31:0] exp;
    cyc++;
    ackSeen = oFIFO_RD;
    chk("oe_n", oOE_N, 1);
    chk("rd_n", oRD_N, 1);
    chk("gpio", oGPIO, 0);
`ifdef FTDI_TEST_PATTERN_EN
    chk("fifo_rd_zero", oFIFO_RD, 0);
`endif
    if (oWR_N === 1'b0) begin
      if (run == 0) begin
        startCyc = cyc;
        chk("start_txe", h2, 0);
        chk("gap_min", highRun >= GAP + 1, 1);
`ifndef FTDI_TEST_PATTERN_EN
        chk("start_level", uh1 >= PW, 1);
`endif
      end
`ifdef FTDI_TEST_PATTERN_EN
      exp = patExp;
      patExp++;
`else
      exp = 32'hDEAD_BEEF;
      if (expQ.size() > 0) exp = expQ.pop_front();
`endif
      chk("data", ioDATA, exp);
      chk("be_on", ioBE, 4'hF);
      chk("pkt_done", oPKT_DONE, run == PW - 1);
      chk("busy_wr", oBUSY, 1);
      run++;
      highRun = 0;
    end else begin
      if (run > 0) begin
        if (!trunc) begin
          chk("pkt_len", run, PW);
          pkts++;
        end
        run = 0;
        trunc = 1'b0;
      end
      chk("be_off", ioBE === 4'hF, 0);
      chk("pkt_done_idle", oPKT_DONE, 0);
      if (iRST_N === 1'b1) chk("busy_gap", oBUSY, highRun < GAP);
      highRun++;
    end
    if (iRST_N !== 1'b1) begin
      if (run > 0) trunc = 1'b1;
      patExp = '0;
      highRun = 1000;
    end
    h2 = h1;
    h1 = iTXE_N;
    uh1 = iFIFO_USEDW;
  end

  initial begin
    int bad;
    int p0;
    int a0;
    int tTxe;
    int k;
    iRST_N = 1'b0;
    iTXE_N = 1'b0;
    drive();
    repeat (3) tick();
    @(negedge clk);
    chk("rst_wr_n", oWR_N, 1);
    chk("rst_fifo_rd", oFIFO_RD, 0);
    chk("rst_busy", oBUSY, 0);
    chk("rst_done", oPKT_DONE, 0);

`ifndef FTDI_TEST_PATTERN_EN
    for (int i = 0; i < PW - 1; i++) fifo.push_back(32'(i));
    drive();
    tick();
    iRST_N = 1'b1;
    bad = 0;
    repeat (20) begin
      tick();
      @(negedge clk);
      if (oWR_N !== 1'b1 || oFIFO_RD !== 1'b0) bad++;
    end
    chk("no_start_1023", bad, 0);
    fifo.push_back(32'(PW - 1));
    drive();
`else
    tick();
    iRST_N = 1'b1;
`endif
    p0 = pkts;
    a0 = acks;
    waitPkts(p0 + 1, 3000, "pkt1_done");
`ifndef FTDI_TEST_PATTERN_EN
    chk("acks_pkt1", acks - a0, PW);
`endif

    for (int i = 0; i < PW; i++) fifo.push_back($urandom);
    drive();
    p0 = pkts;
    waitRun(5, 3000, "pkt2_run5");
    iTXE_N = 1'b1;
    waitPkts(p0 + 1, 3000, "pkt2_done");
    repeat (200) tick();
    for (int i = 0; i < 2 * PW; i++) fifo.push_back($urandom);
    drive();
    repeat (50) tick();
    chk("held_off", pkts, p0 + 1);
    iTXE_N = 1'b0;
    tTxe = cyc + 1;
    k = 0;
    while (startCyc <= tTxe && k < 50) begin
      tick();
      k++;
    end
    chk("start_latency", startCyc - tTxe, 2);
    waitPkts(p0 + 3, 5000, "pkt34_done");

    for (int i = 0; i < PW; i++) fifo.push_back($urandom);
    drive();
    waitRun(500, 3000, "run500");
    iRST_N = 1'b0;
    tick();
    fifo.delete();
    expQ.delete();
    drive();
    @(negedge clk);
    chk("mid_rst_wr_n", oWR_N, 1);
    chk("mid_rst_bus", ioBE === 4'hF, 0);
    chk("mid_rst_busy", oBUSY, 0);
    tick();
    for (int i = 0; i < PW; i++) fifo.push_back($urandom);
    drive();
    iRST_N = 1'b1;
    p0 = pkts;
    a0 = acks;
    waitPkts(p0 + 1, 3000, "fresh_pkt");
`ifndef FTDI_TEST_PATTERN_EN
    chk("acks_fresh", acks - a0, PW);
`endif

    repeat (3000) begin
      iTXE_N = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 1) == 1)
        repeat ($urandom_range(1, 4)) fifo.push_back($urandom);
      tick();
    end

    iTXE_N = 1'b1;
    k = 0;
    while ((run != 0 || highRun < GAP + 2) && k < 3000) begin
      tick();
      k++;
    end
    chk("drain_bound", run == 0, 1);
`ifndef FTDI_TEST_PATTERN_EN
    chk("scoreboard_empty", expQ.size(), 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
